mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Ports SHALL be (name  direction  width  meaning):
 clk  in  1  sole clock, rising edge
 rst  in  1  async active-high reset
 I_mem_read  in  1  I-cache block read request
 I_mem_write  in  1  I-cache block write request (tied 0 by I-cache)
 I_mem_addr  in  28  I-cache block address
 I_mem_wdata  in  128  I-cache write block
 I_mem_ready  out  1  I-cache completion pulse
 I_mem_rdata  out  128  I-cache read block
 D_mem_read  in  1  D-cache block read request
 D_mem_write  in  1  D-cache block write-back request
 D_mem_addr  in  28  D-cache block address
 D_mem_wdata  in  128  D-cache write block
 D_mem_ready  out  1  D-cache completion pulse
 D_mem_rdata  out  128  D-cache read block
 mem_read  out  1  shared memory read strobe
 mem_write  out  1  shared memory write strobe
 mem_addr  out  28  shared memory block address
 mem_wdata  out  128  shared memory write block
 mem_ready  in  1  memory completion pulse
 mem_rdata  in  128  memory read block, valid with mem_ready
 grant  out  2  current owner: 00 none, 01 I, 10 D

Function
REQ-003 All outputs SHALL be registered, with no combinational input-to-output path.
REQ-004 FSM states SHALL be IDLE, SERVE_I, SERVE_D, DONE_I, DONE_D.
REQ-005 Requester protocol SHALL be: read/write held high with stable addr/wdata until the ready pulse; request low in the cycle after ready.
REQ-006 In IDLE with only one requester active, that requester SHALL be granted at the next edge (SERVE_I or SERVE_D).
REQ-007 In IDLE with both requesters active, the one not granted last SHALL win; last_grant SHALL reset to I, so the first tie goes to D.
REQ-008 On grant edge, mem_read/mem_write/mem_addr/mem_wdata SHALL be loaded from the winner, giving request-to-strobe latency of 1 cycle.
REQ-009 In SERVE_x, memory outputs SHALL be held constant and requester inputs ignored until mem_ready is sampled high.
REQ-010 On sampled mem_ready in SERVE_x:
 - mem_read/mem_write SHALL clear.
 - x_mem_rdata SHALL capture mem_rdata (reads only; unchanged on writes).
 - x_mem_ready SHALL assert for exactly one cycle.
 - state SHALL go to DONE_x.
REQ-011 DONE_x SHALL last one cycle, then go to IDLE. Minimum transaction = 3 cycles (grant, ready-capture, done); back-to-back grants are separated by ≥1 IDLE cycle.
REQ-012 mem_ready sampled outside SERVE_x SHALL be ignored.
REQ-013 A requester asserting both read and write SHALL be serviced as a write.
REQ-014 x_mem_rdata SHALL hold its value until that port's next completed read.
REQ-015 grant SHALL be 01 in SERVE_I/DONE_I, 10 in SERVE_D/DONE_D, 00 in IDLE.
REQ-016 A requester's request arriving while the other port is served SHALL wait, and SHALL be granted in the IDLE after DONE.

Reset
REQ-017 Asserting rst SHALL immediately force:
 - state IDLE, last_grant I
 - all outputs 0 (grant 00, strobes 0, addr/wdata/rdata 0)
REQ-018 Reset mid-transaction SHALL abandon the transaction with no ready pulse; a later mem_ready SHALL be ignored.
REQ-019 Operation SHALL resume on the first rising clk edge after rst deasserts.

Verification
REQ-020 I read 0x0000010 alone; memory responds 4 cycles after strobe with 0xAAAA…:
 -> mem_read rises 1 cycle after request
 -> I_mem_ready pulses once; I_mem_rdata = 0xAAAA…
REQ-021 I read and D write issued in the same cycle after reset:
 -> D served first
 -> I granted in the IDLE after DONE_D
 -> grant sequence 10,10,…,00,01
REQ-022 Repeated simultaneous requests: grants alternate D, I, D, I.
REQ-023 D request arrives while I is being served:
 -> I outputs unaffected
 -> D strobe asserts 2 cycles after I_mem_ready
REQ-024 rst pulsed during SERVE_D, memory responds later:
 -> no D_mem_ready
 -> all outputs 0
 -> next request served normally
REQ-025 Spurious mem_ready in IDLE: no state change and no ready pulse.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of I-cache, D-cache and shared-memory signals around the two-port memory arbiter.
// slave is the arbiter's view; master is the view of the caches plus memory combined.
interface mem_arbiter_if;
  logic         I_mem_read;
  logic         I_mem_write;
  logic [27:0]  I_mem_addr;
  logic [127:0] I_mem_wdata;
  logic         I_mem_ready;
  logic [127:0] I_mem_rdata;

  logic         D_mem_read;
  logic         D_mem_write;
  logic [27:0]  D_mem_addr;
  logic [127:0] D_mem_wdata;
  logic         D_mem_ready;
  logic [127:0] D_mem_rdata;

  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic         mem_ready;
  logic [127:0] mem_rdata;

  logic [1:0]   grant;

  modport slave (
    input  I_mem_read, I_mem_write, I_mem_addr, I_mem_wdata,
    output I_mem_ready, I_mem_rdata,
    input  D_mem_read, D_mem_write, D_mem_addr, D_mem_wdata,
    output D_mem_ready, D_mem_rdata,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata,
    output grant
  );

  modport master (
    output I_mem_read, I_mem_write, I_mem_addr, I_mem_wdata,
    input  I_mem_ready, I_mem_rdata,
    output D_mem_read, D_mem_write, D_mem_addr, D_mem_wdata,
    input  D_mem_ready, D_mem_rdata,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_ready, mem_rdata,
    input  grant
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (I-cache / D-cache) arbiter onto a single block memory.
// Round-robin on ties, one transaction at a time, all outputs registered.
module mem_arbiter (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle,
    StServeI,
    StServeD,
    StDoneI,
    StDoneD
  } state_e;

  state_e       state_q, state_d;
  logic         last_d_q, last_d_d;  // 1: D was granted most recently
  logic [1:0]   grant_q, grant_d;
  logic         mem_read_q, mem_read_d;
  logic         mem_write_q, mem_write_d;
  logic [27:0]  mem_addr_q, mem_addr_d;
  logic [127:0] mem_wdata_q, mem_wdata_d;
  logic         i_ready_q, i_ready_d;
  logic [127:0] i_rdata_q, i_rdata_d;
  logic         d_ready_q, d_ready_d;
  logic [127:0] d_rdata_q, d_rdata_d;

  logic req_i, req_d;
  assign req_i = bus.I_mem_read | bus.I_mem_write;
  assign req_d = bus.D_mem_read | bus.D_mem_write;

  always_comb begin
    state_d     = state_q;
    last_d_d    = last_d_q;
    grant_d     = grant_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_ready_d   = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_ready_d   = 1'b0;
    d_rdata_d   = d_rdata_q;

    unique case (state_q)
      StIdle: begin
        // D wins a tie unless it was the last owner; write beats read.
        if (req_d && (!req_i || !last_d_q)) begin
          state_d     = StServeD;
          grant_d     = 2'b10;
          last_d_d    = 1'b1;
          mem_write_d = bus.D_mem_write;
          mem_read_d  = bus.D_mem_read & ~bus.D_mem_write;
          mem_addr_d  = bus.D_mem_addr;
          mem_wdata_d = bus.D_mem_wdata;
        end else if (req_i) begin
          state_d     = StServeI;
          grant_d     = 2'b01;
          last_d_d    = 1'b0;
          mem_write_d = bus.I_mem_write;
          mem_read_d  = bus.I_mem_read & ~bus.I_mem_write;
          mem_addr_d  = bus.I_mem_addr;
          mem_wdata_d = bus.I_mem_wdata;
        end
      end
      StServeI: begin
        if (bus.mem_ready) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (mem_read_q) i_rdata_d = bus.mem_rdata;
          i_ready_d   = 1'b1;
          state_d     = StDoneI;
        end
      end
      StServeD: begin
        if (bus.mem_ready) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (mem_read_q) d_rdata_d = bus.mem_rdata;
          d_ready_d   = 1'b1;
          state_d     = StDoneD;
        end
      end
      StDoneI, StDoneD: begin
        state_d = StIdle;
        grant_d = 2'b00;
      end
      default: begin
        state_d = StIdle;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      last_d_q    <= 1'b0;
      grant_q     <= 2'b00;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_ready_q   <= 1'b0;
      i_rdata_q   <= '0;
      d_ready_q   <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_d_q    <= last_d_d;
      grant_q     <= grant_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_ready_q   <= i_ready_d;
      i_rdata_q   <= i_rdata_d;
      d_ready_q   <= d_ready_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.mem_read    = mem_read_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.I_mem_ready = i_ready_q;
  assign bus.I_mem_rdata = i_rdata_q;
  assign bus.D_mem_ready = d_ready_q;
  assign bus.D_mem_rdata = d_rdata_q;

endmodule
